// File: rtl/keypad_pkg.sv
// Shared types and lookup helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_t;

    // Active-low column drive patterns, entry 0 in the low nibble.
    localparam logic [15:0] COL_PATTERN = 16'h7BDE;

    // Nibble at index row*4+col is the hex legend of that key.
    localparam logic [63:0] KEY_TABLE = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        int base;
        base = 4 * int'(idx);
        return COL_PATTERN[base +: 4];
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        int base;
        base = 4 * int'({row, col});
        return KEY_TABLE[base +: 4];
    endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running dwell counter; o_tick is high in the last cycle of every SCAN_RATIO-cycle dwell.
module scan_tick #(
    parameter int unsigned SCAN_RATIO = 2048
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    logic [15:0] r_count;

    assign o_tick = (r_count == 16'(SCAN_RATIO - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, per-frame key classification, frame-level debounce and
// a 4-digit shift register of accepted keys.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_RATIO      = 2048,
    parameter int unsigned DEBOUNCE_FRAMES = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [3:0]  i_row,
    input  logic        i_clear,
    output logic [3:0]  o_column,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_held,
    output logic [15:0] o_digits
);

    logic        w_tick;
    logic        w_frame_end;
    logic [3:0]  r_row_meta;
    logic [3:0]  r_row_sync;
    logic [1:0]  r_col_idx;
    logic [1:0]  r_acc_cnt;
    logic [3:0]  r_acc_code;
    logic [2:0]  w_col_cnt;
    logic [1:0]  w_col_row;
    logic [2:0]  w_tot;
    logic [3:0]  w_code;
    logic        w_single;
    logic        w_none;
    state_t      r_state;
    state_t      w_state_d;
    logic [3:0]  r_dcnt;
    logic [3:0]  w_dcnt_d;
    logic [3:0]  w_dcnt_inc;
    logic [3:0]  r_cand;
    logic [3:0]  w_cand_d;
    logic        w_accept;
    logic        r_key_valid;
    logic [3:0]  r_key_code;
    logic [15:0] r_digits;

    scan_tick #(
        .SCAN_RATIO(SCAN_RATIO)
    ) u_scan_tick (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .o_tick (w_tick)
    );

    assign w_frame_end = w_tick && (r_col_idx == 2'd3);

    // Pressed keys in the current column, combined with earlier columns of this frame.
    always_comb begin
        w_col_cnt = 3'd0;
        w_col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_row_sync[r]) begin
                w_col_cnt = w_col_cnt + 3'd1;
                w_col_row = 2'(r);
            end
        end
        w_tot    = {1'b0, r_acc_cnt} + w_col_cnt;
        w_code   = (r_acc_cnt == 2'd0) ? key_map(w_col_row, r_col_idx) : r_acc_code;
        w_single = (w_tot == 3'd1);
        w_none   = (w_tot == 3'd0);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
            r_col_idx  <= 2'd0;
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
            if (w_tick) begin
                r_col_idx <= r_col_idx + 2'd1;
                if (w_frame_end) begin
                    r_acc_cnt  <= 2'd0;
                    r_acc_code <= 4'd0;
                end else begin
                    r_acc_cnt  <= (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
                    r_acc_code <= w_code;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= StIdle;
            r_dcnt  <= 4'd0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_dcnt  <= w_dcnt_d;
            r_cand  <= w_cand_d;
        end
    end

    assign w_dcnt_inc = (r_dcnt == 4'hF) ? r_dcnt : r_dcnt + 4'd1;

    always_comb begin
        w_state_d = r_state;
        w_dcnt_d  = r_dcnt;
        w_cand_d  = r_cand;
        w_accept  = 1'b0;
        if (w_frame_end) begin
            unique case (r_state)
                StIdle: begin
                    if (w_single) begin
                        w_cand_d = w_code;
                        if (DEBOUNCE_FRAMES == 1) begin
                            w_accept  = 1'b1;
                            w_state_d = StPressed;
                            w_dcnt_d  = 4'd0;
                        end else begin
                            w_state_d = StDebounce;
                            w_dcnt_d  = 4'd1;
                        end
                    end
                end
                StDebounce: begin
                    if (w_single && (w_code == r_cand)) begin
                        w_dcnt_d = w_dcnt_inc;
                        if (w_dcnt_inc >= 4'(DEBOUNCE_FRAMES)) begin
                            w_accept  = 1'b1;
                            w_state_d = StPressed;
                            w_dcnt_d  = 4'd0;
                        end
                    end else begin
                        w_state_d = StIdle;
                        w_dcnt_d  = 4'd0;
                    end
                end
                StPressed: begin
                    if (w_none) begin
                        w_state_d = (DEBOUNCE_FRAMES == 1) ? StIdle : StRelease;
                        w_dcnt_d  = (DEBOUNCE_FRAMES == 1) ? 4'd0 : 4'd1;
                    end
                end
                StRelease: begin
                    if (w_none) begin
                        w_dcnt_d = w_dcnt_inc;
                        if (w_dcnt_inc >= 4'(DEBOUNCE_FRAMES)) begin
                            w_state_d = StIdle;
                            w_dcnt_d  = 4'd0;
                        end
                    end else begin
                        w_state_d = StPressed;
                        w_dcnt_d  = 4'd0;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_dcnt_d  = 4'd0;
                end
            endcase
        end
    end

    // Clear takes priority over a same-edge shift; the pulse and code still update.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_digits    <= 16'd0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_code;
            end
            if (i_clear) begin
                r_digits <= 16'd0;
            end else if (w_accept) begin
                r_digits <= {r_digits[11:0], w_code};
            end
        end
    end

    always_comb begin
        o_column    = col_pattern(r_col_idx);
        o_key_held  = (r_state == StPressed) || (r_state == StRelease);
        o_key_valid = r_key_valid;
        o_key_code  = r_key_code;
        o_digits    = r_digits;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_RATIO=8, DEBOUNCE_FRAMES=3 (32-cycle frames).
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  row;
    logic [3:0]  column;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits;

    logic [15:0] keys = 16'd0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;
    int hcount = 0;

    keypad_scanner #(
        .SCAN_RATIO     (8),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_row      (row),
        .i_clear    (clear),
        .o_column   (column),
        .o_key_code (key_code),
        .o_key_valid(key_valid),
        .o_key_held (key_held),
        .o_digits   (digits)
    );

    always #5 clock = ~clock;

    // Keypad model: row r pulled low when column c is driven low and key (r,c) is down.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !column[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (key_valid) vcount <= vcount + 1;
        if (key_held) hcount <= hcount + 1;
    end

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 10000) begin
            @(negedge clock);
            guard++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: cycle %0d, required %0d", cyc, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col [5];
        exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        keys = 16'd0;
        do_reset();
        checks++;
        if (column !== 4'b1110) begin
            errors++; $display("FAIL reset_column: got %b want 1110", column);
        end
        checks++;
        if (digits !== 16'h0000) begin
            errors++; $display("FAIL reset_digits: got %h want 0000", digits);
        end
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b held=%b code=%h want 0 0 0",
                     key_valid, key_held, key_code);
        end
        for (int i = 1; i < 5; i++) begin
            wait_cyc(8 * i - 1);
            checks++;
            if (column !== exp_col[i-1]) begin
                errors++;
                $display("FAIL col_hold_%0d: got %b want %b", i, column, exp_col[i-1]);
            end
            wait_cyc(8 * i);
            checks++;
            if (column !== exp_col[i]) begin
                errors++;
                $display("FAIL col_step_%0d: got %b want %b", i, column, exp_col[i]);
            end
        end
    endtask

    task automatic test_single_press();
        int v0;
        keys = 16'h0020;
        do_reset();
        v0 = vcount;
        wait_cyc(95);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got valid=%b want 0", key_valid);
        end
        wait_cyc(96);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h5) begin
            errors++;
            $display("FAIL single_accept: got valid=%b code=%h want 1 5", key_valid, key_code);
        end
        checks++;
        if (digits !== 16'h0005 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL single_digits: got %h held=%b want 0005 1", digits, key_held);
        end
        wait_cyc(97);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse_width: got valid=%b want 0", key_valid);
        end
        wait_cyc(320);
        keys = 16'd0;
        wait_cyc(415);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL release_hold: got held=%b want 1", key_held);
        end
        wait_cyc(416);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL release_drop: got held=%b want 0", key_held);
        end
        wait_cyc(420);
        checks++;
        if (vcount - v0 !== 1) begin
            errors++; $display("FAIL single_count: got %0d pulses want 1", vcount - v0);
        end
    endtask

    task automatic test_bounce();
        int v0;
        int h0;
        keys = 16'd0;
        do_reset();
        v0 = vcount;
        h0 = hcount;
        keys = 16'h0040;
        wait_cyc(64);
        keys = 16'd0;
        wait_cyc(320);
        checks++;
        if (vcount - v0 !== 0) begin
            errors++; $display("FAIL bounce_pulses: got %0d want 0", vcount - v0);
        end
        checks++;
        if (hcount - h0 !== 0 || key_held !== 1'b0) begin
            errors++; $display("FAIL bounce_held: got %0d held cycles want 0", hcount - h0);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] codes [5];
        int         bits [5];
        int         v0;
        int         t;
        codes = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
        bits  = '{0, 1, 2, 3, 4};
        keys = 16'd0;
        do_reset();
        v0 = vcount;
        for (int i = 0; i < 5; i++) begin
            t = 320 * i;
            wait_cyc(t);
            keys = 16'd1 << bits[i];
            wait_cyc(t + 96);
            checks++;
            if (key_valid !== 1'b1 || key_code !== codes[i]) begin
                errors++;
                $display("FAIL seq_accept_%0d: got valid=%b code=%h want 1 %h",
                         i, key_valid, key_code, codes[i]);
            end
            wait_cyc(t + 160);
            keys = 16'd0;
        end
        wait_cyc(1600);
        checks++;
        if (vcount - v0 !== 5) begin
            errors++; $display("FAIL seq_count: got %0d pulses want 5", vcount - v0);
        end
        checks++;
        if (digits !== 16'h23A4) begin
            errors++; $display("FAIL seq_digits: got %h want 23a4", digits);
        end
    endtask

    // Runs on directly from test_sequence so digits are non-zero when clear hits.
    task automatic test_ghost_clear();
        int v0;
        v0 = vcount;
        keys = 16'h0003;
        wait_cyc(1792);
        keys = 16'd0;
        wait_cyc(1856);
        checks++;
        if (vcount - v0 !== 0 || digits !== 16'h23A4) begin
            errors++;
            $display("FAIL ghost: got %0d pulses digits=%h want 0 23a4", vcount - v0, digits);
        end
        keys = 16'h0100;
        wait_cyc(1951);
        clear = 1'b1;
        wait_cyc(1952);
        clear = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h7) begin
            errors++;
            $display("FAIL clear_accept: got valid=%b code=%h want 1 7", key_valid, key_code);
        end
        checks++;
        if (digits !== 16'h0000) begin
            errors++; $display("FAIL clear_digits: got %h want 0000", digits);
        end
        wait_cyc(1953);
        checks++;
        if (digits !== 16'h0000 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: got digits=%h valid=%b want 0000 0", digits, key_valid);
        end
    endtask

    task automatic test_reset_mid_hold();
        wait_cyc(1960);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL midhold_pre: got held=%b want 1", key_held);
        end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if (column !== 4'b1110 || digits !== 16'h0000) begin
            errors++;
            $display("FAIL midhold_reset: got column=%b digits=%h want 1110 0000", column, digits);
        end
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL midhold_flags: got valid=%b held=%b code=%h want 0 0 0",
                     key_valid, key_held, key_code);
        end
        wait_cyc(95);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL midhold_early: got valid=%b want 0", key_valid);
        end
        wait_cyc(96);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'h7 || digits !== 16'h0007) begin
            errors++;
            $display("FAIL midhold_reaccept: got valid=%b code=%h digits=%h want 1 7 0007",
                     key_valid, key_code, digits);
        end
        keys = 16'd0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_sequence();
        test_ghost_clear();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix hex keypad: drives one column low at a time, samples the active-low rows, debounces, and reports each accepted key once.
- Input-side counterpart of the multiplexed seven-segment display path.
- Accepted keys shift into a 16-bit, 4-digit register that connects directly to the display multiplexer's four 4-bit digit inputs.

Parameters:
- SCAN_RATIO, 2048, clock cycles each column stays driven (dwell); legal range 4..65535.
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or a release; legal range 1..15.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset
- row  input  4  keypad rows, active-low, asynchronous to clock
- clear  input  1  synchronous clear of digits
- column  output  4  keypad column drive, active-low, exactly one bit low
- key_code  output  4  last accepted key code
- key_valid  output  1  single-cycle pulse when a key is accepted
- key_held  output  1  high while an accepted key is still down
- digits  output  16  last four accepted keys; [3:0] is the newest

Behaviour:
- Reset (reset==0 at a clock edge):
  - column=4'b1110; key_code=0; key_valid=0; key_held=0; digits=0.
  - FSM goes to IDLE; all counters go to 0.
  - Reset mid-operation abandons any frame or debounce in progress; no pulse is emitted.
- Column scan:
  - Sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - The column advances every SCAN_RATIO cycles, on the cycle the internal tick is high.
  - One frame = 4*SCAN_RATIO cycles, starting at column 1110.
- Row sampling:
  - row passes through a 2-flop synchronizer.
  - The synchronized row is sampled in the last cycle of each dwell, at the tick.
  - A low bit means key (row r, active column c) is pressed.
- Key map, row0..3 with columns 0..3 left to right:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Frame result, evaluated at the end of column 3:
  - NONE: no pressed bits.
  - SINGLE(code): exactly one pressed bit.
  - MULTI: two or more pressed bits; treated as NONE for acceptance.
- FSM, advancing once per frame end:
  - IDLE: SINGLE(k) -> DEBOUNCE with candidate=k, cnt=1. If DEBOUNCE_FRAMES==1, go straight to accept instead.
  - DEBOUNCE: SINGLE(same k) -> cnt+1. When cnt reaches DEBOUNCE_FRAMES, accept and go to PRESSED. A different key, MULTI or NONE -> IDLE with no pulse.
  - Accept: in the cycle after the frame end, key_valid=1 for exactly one cycle, key_code=k, digits <= {digits[11:0], k}.
  - PRESSED: key_held=1. NONE -> RELEASE with cnt=1. Any key (same, different or MULTI) stays in PRESSED; there is no rollover.
  - RELEASE: key_held stays 1. NONE counts up; at DEBOUNCE_FRAMES -> IDLE with key_held=0. Any key -> PRESSED.
- key_code holds its value between accepts.
- clear: digits=0 on the next edge. If clear and accept occur on the same edge, clear wins for digits, while key_valid and key_code still update.
- Widths:
  - Dwell counter is 16 bits, wraps at SCAN_RATIO-1.
  - Debounce counter is 4 bits and saturates; it never wraps.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - the 4-entry column pattern constant;
  - the key-map function (row, column) -> 4-bit code.
- Sub-module scan_tick: a counter producing a one-cycle tick every SCAN_RATIO cycles, with the same synchronous active-low reset. It is instantiated once.

Test Plan:
All scenarios use SCAN_RATIO=8 and DEBOUNCE_FRAMES=3 (frame = 32 cycles). The bench keypad model pulls row r low whenever column c is low and key (r,c) is pressed.
- Reset: reset low for 3 cycles, then high. Immediately: column=1110, digits=0, key_valid=0. Column then steps every 8 cycles through 1101, 1011, 0111, 1110.
- Single press: hold key 5 (row1, col1) for 10 frames. Required: exactly one key_valid, in the cycle after the 3rd frame end; key_code=5; digits=16'h0005. key_held falls 3 frames after release.
- Bounce: press 6 for 2 frames, release. Required: no key_valid; key_held stays 0.
- Sequence: press and release 1, 2, 3, A, 4, each held 5 frames and released 5 frames. Required: five pulses; digits=16'h23A4.
- Ghosting and clear: hold 1 and 2 together for 6 frames; required: no pulse. Then assert clear on the same cycle as the pulse from accepting 7; required: digits=0, key_code=7, key_valid=1.
- Reset mid-hold: while key_held=1, pulse reset low for 1 cycle. Required: all outputs return to reset values. With the key still held, it is re-accepted after 3 frames.
